nios2_debug_cmd_sysclk: RTL and testbench

Parametrised system-clock-side command stage for the Nios II JTAG debug slave. It takes the virtual-JTAG update-IR/update-DR indications and the shifted data register from the TCK side, resynchronises them into `clk`, and latches the data onto `jdo`. It then issues per-instruction `take_action` / `take_no_action` strobes to the OCI blocks: break, ocimem, tracectrl and others. It generalises the fixed 2-bit-IR / 38-bit-DR stage with these additions:
- configurable IR and DR widths;
- configurable synchroniser depth;
- an optional acknowledge mode with overrun detection.

---
 rtl/nios2_debug_cmd_sysclk.sv | 145 ++++++++++++++
 tb/tb_nios2_debug_cmd_sysclk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_cmd_sysclk.sv
// System-clock side of the Nios II JTAG debug command path: resynchronises
// update-IR/update-DR, latches jdo/ir_q and issues one-hot per-instruction strobes.
module nios2_debug_cmd_sysclk #(
  parameter int unsigned SR_WIDTH    = 38,
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_BIT     = 35,
  parameter int unsigned ACK_MODE    = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  input  logic                       cmd_ack,
  input  logic                       clr_overrun,
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [IR_WIDTH-1:0]        ir_q,
  output logic [(2**IR_WIDTH)-1:0]   take_action,
  output logic [(2**IR_WIDTH)-1:0]   take_no_action,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned NCH    = 2**IR_WIDTH;
  localparam int unsigned FILL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT_ACK
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  udr_sync_q;
  logic [SYNC_STAGES-1:0]  uir_sync_q;
  logic                    udr_hist_q;
  logic                    uir_hist_q;
  logic [FILL_W-1:0]       fill_q;
  logic                    udr_armed_q;

  logic                    udr_last;
  logic                    uir_last;
  logic                    udr_rise;
  logic                    uir_rise;
  logic                    fill_done;
  logic [IR_WIDTH-1:0]     issue_ir;
  logic [NCH-1:0]          issue_sel;

  assign udr_last  = udr_sync_q[SYNC_STAGES-1];
  assign uir_last  = uir_sync_q[SYNC_STAGES-1];
  assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));

  // A UDR edge only counts once the chain has seen vs_udr low after reset.
  assign udr_rise  = udr_armed_q & udr_last & ~udr_hist_q;
  assign uir_rise  = uir_last & ~uir_hist_q;

  // A same-cycle IR update takes precedence over the held instruction.
  assign issue_ir  = uir_rise ? ir_in : ir_q;
  assign issue_sel = NCH'(1) << issue_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      udr_sync_q     <= '0;
      uir_sync_q     <= '0;
      udr_hist_q     <= 1'b0;
      uir_hist_q     <= 1'b0;
      fill_q         <= '0;
      udr_armed_q    <= 1'b0;
      jdo            <= '0;
      ir_q           <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_hist_q <= udr_last;
      uir_hist_q <= uir_last;

      if (!fill_done) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      if (fill_done && !udr_last) begin
        udr_armed_q <= 1'b1;
      end

      if (uir_rise) begin
        ir_q <= ir_in;
      end

      // Set beats clear when both land in the same cycle.
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
      if (udr_rise && (state_q != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (udr_rise) begin
            jdo     <= sr;
            busy    <= 1'b1;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (jdo[ACT_BIT]) begin
            take_action    <= issue_sel;
          end else begin
            take_no_action <= issue_sel;
          end
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if ((ACK_MODE == 0) || cmd_ack) begin
            take_action    <= '0;
            take_no_action <= '0;
            busy           <= 1'b0;
            state_q        <= S_IDLE;
          end else begin
            state_q        <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (cmd_ack) begin
            take_action    <= '0;
            take_no_action <= '0;
            busy           <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk.sv
// Directed bench for nios2_debug_cmd_sysclk: default, ack-mode and wide/3-stage
// configurations driven from vector tables plus hand-written corner sequences.
module tb_nios2_debug_cmd_sysclk;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: defaults (IR 2, SR 38, 2 sync stages, no ack)
  logic        vs_udr_a = 0, vs_uir_a = 0, cmd_ack_a = 0, clr_a = 0;
  logic [1:0]  ir_in_a = '0, ir_q_a;
  logic [37:0] sr_a = '0, jdo_a;
  logic [3:0]  act_a, noact_a;
  logic        busy_a, ovr_a;

  // Instance B: ack mode
  logic        vs_udr_b = 0, vs_uir_b = 0, cmd_ack_b = 0, clr_b = 0;
  logic [1:0]  ir_in_b = '0, ir_q_b;
  logic [37:0] sr_b = '0, jdo_b;
  logic [3:0]  act_b, noact_b;
  logic        busy_b, ovr_b;

  // Instance C: IR 3, SR 44, 3 sync stages, ACT_BIT 40
  logic        vs_udr_c = 0, vs_uir_c = 0, cmd_ack_c = 0, clr_c = 0;
  logic [2:0]  ir_in_c = '0, ir_q_c;
  logic [43:0] sr_c = '0, jdo_c;
  logic [7:0]  act_c, noact_c;
  logic        busy_c, ovr_c;

  nios2_debug_cmd_sysclk dut_a (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr_a), .vs_uir(vs_uir_a),
    .ir_in(ir_in_a), .sr(sr_a), .cmd_ack(cmd_ack_a), .clr_overrun(clr_a),
    .jdo(jdo_a), .ir_q(ir_q_a), .take_action(act_a), .take_no_action(noact_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  nios2_debug_cmd_sysclk #(.ACK_MODE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr_b), .vs_uir(vs_uir_b),
    .ir_in(ir_in_b), .sr(sr_b), .cmd_ack(cmd_ack_b), .clr_overrun(clr_b),
    .jdo(jdo_b), .ir_q(ir_q_b), .take_action(act_b), .take_no_action(noact_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  nios2_debug_cmd_sysclk #(.SR_WIDTH(44), .IR_WIDTH(3), .SYNC_STAGES(3), .ACT_BIT(40)) dut_c (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr_c), .vs_uir(vs_uir_c),
    .ir_in(ir_in_c), .sr(sr_c), .cmd_ack(cmd_ack_c), .clr_overrun(clr_c),
    .jdo(jdo_c), .ir_q(ir_q_c), .take_action(act_c), .take_no_action(noact_c),
    .busy(busy_c), .overrun(ovr_c)
  );

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
    logic        simul;
    logic [3:0]  exp_act;
    logic [3:0]  exp_noact;
  } vec_a_t;

  typedef struct {
    logic [2:0]  ir;
    logic [43:0] sr;
    logic [7:0]  exp_act;
    logic [7:0]  exp_noact;
  } vec_c_t;

  vec_a_t va[5];
  vec_c_t vc[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One command on A; UIR either precedes the DR update or coincides with it.
  task automatic a_cmd(input vec_a_t v);
    if (!v.simul) begin
      @(negedge clk); ir_in_a = v.ir; vs_uir_a = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); vs_uir_a = 1'b0;
      chk("a_ir_q", 64'(ir_q_a), 64'(v.ir));
      repeat (4) @(negedge clk);
    end
    @(negedge clk); sr_a = v.sr; vs_udr_a = 1'b1;
    if (v.simul) begin
      ir_in_a = v.ir; vs_uir_a = 1'b1;
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("a_busy_k1", 64'(busy_a), 64'(0));
    chk("a_strobe_k1", 64'({act_a, noact_a}), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("a_jdo_k2", 64'(jdo_a), 64'(v.sr));
    chk("a_irq_k2", 64'(ir_q_a), 64'(v.ir));
    chk("a_busy_k2", 64'(busy_a), 64'(1));
    chk("a_strobe_k2", 64'({act_a, noact_a}), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("a_act_k3", 64'(act_a), 64'(v.exp_act));
    chk("a_noact_k3", 64'(noact_a), 64'(v.exp_noact));
    @(posedge clk); @(negedge clk);
    chk("a_strobe_k4", 64'({act_a, noact_a}), 64'(0));
    chk("a_busy_k4", 64'(busy_a), 64'(0));
    chk("a_ovr", 64'(ovr_a), 64'(0));
    vs_udr_a = 1'b0; vs_uir_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic b_set_ir(input logic [1:0] ir);
    @(negedge clk); ir_in_b = ir; vs_uir_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); vs_uir_b = 1'b0;
    chk("b_ir_q", 64'(ir_q_b), 64'(ir));
    repeat (4) @(negedge clk);
  endtask

  task automatic c_cmd(input vec_c_t v);
    @(negedge clk); ir_in_c = v.ir; vs_uir_c = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); vs_uir_c = 1'b0;
    chk("c_ir_q", 64'(ir_q_c), 64'(v.ir));
    repeat (5) @(negedge clk);
    sr_c = v.sr; vs_udr_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("c_busy_k2", 64'(busy_c), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("c_jdo_k3", 64'(jdo_c), 64'(v.sr));
    chk("c_strobe_k3", 64'({act_c, noact_c}), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("c_act_k4", 64'(act_c), 64'(v.exp_act));
    chk("c_noact_k4", 64'(noact_c), 64'(v.exp_noact));
    @(posedge clk); @(negedge clk);
    chk("c_strobe_k5", 64'({act_c, noact_c}), 64'(0));
    chk("c_busy_k5", 64'(busy_c), 64'(0));
    vs_udr_c = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic bad;
    logic held;
    vec_a_t vr;

    va[0] = '{ir: 2'd1, sr: 38'h08_0000_1234, simul: 1'b0, exp_act: 4'b0010, exp_noact: 4'b0000};
    va[1] = '{ir: 2'd3, sr: 38'h00_0000_00FF, simul: 1'b0, exp_act: 4'b0000, exp_noact: 4'b1000};
    va[2] = '{ir: 2'd0, sr: 38'h37_FFFF_FFFF, simul: 1'b0, exp_act: 4'b0000, exp_noact: 4'b0001};
    va[3] = '{ir: 2'd2, sr: 38'h08_0000_0000, simul: 1'b0, exp_act: 4'b0100, exp_noact: 4'b0000};
    va[4] = '{ir: 2'd1, sr: 38'h08_0000_0001, simul: 1'b1, exp_act: 4'b0010, exp_noact: 4'b0000};
    for (int i = 0; i < 8; i++) begin
      vc[i].ir        = 3'(i);
      vc[i].sr        = {((i % 2) == 0) ? 4'h9 : 4'h8, 40'h12_3456_7800 | 40'(i)};
      vc[i].exp_act   = ((i % 2) == 0) ? (8'(1) << i) : 8'h00;
      vc[i].exp_noact = ((i % 2) == 1) ? (8'(1) << i) : 8'h00;
    end

    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_jdo", 64'(jdo_a), 64'(0));
    chk("rst_irq", 64'(ir_q_a), 64'(0));
    chk("rst_strobe", 64'({act_a, noact_a}), 64'(0));
    chk("rst_busy_ovr", 64'({busy_a, ovr_a}), 64'(0));
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 5; i++) a_cmd(va[i]);

    // Asynchronous reset during ISSUE with vs_udr still high
    @(negedge clk); sr_a = 38'h08_0000_0055; vs_udr_a = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("a_pre_rst_act", 64'(act_a), 64'(4'b0010));
    reset_n = 1'b0;
    #1;
    chk("a_rst_jdo", 64'(jdo_a), 64'(0));
    chk("a_rst_irq", 64'(ir_q_a), 64'(0));
    chk("a_rst_strobe", 64'({act_a, noact_a}), 64'(0));
    chk("a_rst_busy_ovr", 64'({busy_a, ovr_a}), 64'(0));
    @(negedge clk); reset_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ((act_a != 0) || (noact_a != 0) || busy_a) bad = 1'b1;
    end
    chk("a_no_strobe_after_rst", 64'(bad), 64'(0));
    vs_udr_a = 1'b0;
    repeat (4) @(negedge clk);
    vr = '{ir: 2'd0, sr: 38'h08_0000_0055, simul: 1'b0, exp_act: 4'b0001, exp_noact: 4'b0000};
    a_cmd(vr);

    // Ack mode: strobe held, second DR update dropped and flagged
    b_set_ir(2'd2);
    @(negedge clk); sr_b = 38'h08_0000_00AA; vs_udr_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b_act_issue", 64'(act_b), 64'(4'b0100));
    vs_udr_b = 1'b0;
    held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ((act_b != 4'b0100) || (noact_b != 0) || !busy_b) held = 1'b0;
      if (c == 2) begin sr_b = 38'h00_1111_2222; vs_udr_b = 1'b1; end
      if (c == 6) vs_udr_b = 1'b0;
    end
    chk("b_ack_hold", 64'(held), 64'(1));
    chk("b_jdo_kept", 64'(jdo_b), 64'(38'h08_0000_00AA));
    chk("b_overrun_set", 64'(ovr_b), 64'(1));
    cmd_ack_b = 1'b1;
    @(negedge clk);
    chk("b_strobe_after_ack", 64'({act_b, noact_b}), 64'(0));
    chk("b_busy_after_ack", 64'(busy_b), 64'(0));
    chk("b_overrun_sticky", 64'(ovr_b), 64'(1));
    cmd_ack_b = 1'b0; clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    chk("b_overrun_clr", 64'(ovr_b), 64'(0));

    // Ack already high in ISSUE: single-cycle strobe
    repeat (3) @(negedge clk);
    cmd_ack_b = 1'b1; sr_b = 38'h00_0000_0011; vs_udr_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b_early_ack_noact", 64'({act_b, noact_b}), 64'(8'b0000_0100));
    @(posedge clk); @(negedge clk);
    chk("b_early_ack_drop", 64'({busy_b, act_b, noact_b}), 64'(0));
    vs_udr_b = 1'b0; cmd_ack_b = 1'b0;

    // Overrun set and clear in the same cycle: set wins
    repeat (4) @(negedge clk);
    sr_b = 38'h08_0000_0022; vs_udr_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b_act_issue2", 64'(act_b), 64'(4'b0100));
    vs_udr_b = 1'b0;
    repeat (3) @(negedge clk);
    clr_b = 1'b1; vs_udr_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_ovr_before_set", 64'(ovr_b), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("b_set_wins", 64'(ovr_b), 64'(1));
    @(posedge clk); @(negedge clk);
    chk("b_clr_after_set", 64'(ovr_b), 64'(0));
    clr_b = 1'b0; vs_udr_b = 1'b0; cmd_ack_b = 1'b1;
    @(negedge clk); cmd_ack_b = 1'b0;
    chk("b_busy_final", 64'(busy_b), 64'(0));

    for (int i = 0; i < 8; i++) c_cmd(vc[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
